// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. A clock divider makes one pixel
// tick every CLK_DIV cycles of clk_50MHz. Each tick advances the horizontal
// and vertical counters. Every output is registered and decoded from the new
// count values at the same edge, so the flags never lag the counts.
//
// Ports:
//   clk_50MHz   in   system clock; all logic runs on the rising edge
//   clear       in   synchronous active-high reset; overrides enable
//   enable      in   1 = run; 0 = hold the divider, counts and levels, and force strobes low
//   pix_en      out  1-cycle strobe after a pixel tick
//   h_count     out  pixel column, 0..H_TOTAL-1
//   v_count     out  line, 0..V_TOTAL-1
//   h_sync      out  horizontal sync; H_SYNC_POL while active
//   v_sync      out  vertical sync; V_SYNC_POL while active
//   h_disp      out  h_count < H_DISP
//   v_disp      out  v_count < V_DISP
//   bright      out  h_disp & v_disp
//   line_start  out  pix_en strobe where h_count became 0
//   frame_start out  pix_en strobe where (h_count, v_count) became (0, 0)
module vga_timing_gen #(
    parameter int H_DISP     = 640,
    parameter int H_FP       = 16,
    parameter int H_PW       = 96,
    parameter int H_BP       = 48,
    parameter int V_DISP     = 480,
    parameter int V_FP       = 10,
    parameter int V_PW       = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 10
) (
    input  logic             clk_50MHz,
    input  logic             clear,
    input  logic             enable,
    output logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             h_sync,
    output logic             v_sync,
    output logic             h_disp,
    output logic             v_disp,
    output logic             bright,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_PW + V_BP;
    localparam int H_SYNC_LO = H_DISP + H_FP;
    localparam int H_SYNC_HI = H_DISP + H_FP + H_PW;
    localparam int V_SYNC_LO = V_DISP + V_FP;
    localparam int V_SYNC_HI = V_DISP + V_FP + V_PW;
    // A divide-by-1 still needs a 1-bit counter; it simply stays at zero.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Reject parameter sets that cannot work.
    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_bad_width
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    // Return 1 when lo <= cnt < hi. The count is widened to int so that a
    // bound equal to 2**CNT_W compares correctly.
    function automatic logic in_range(input logic [CNT_W-1:0] cnt, input int lo, input int hi);
        return (int'(cnt) >= lo) && (int'(cnt) < hi);
    endfunction

    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;
    logic             h_wrap_s;
    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;

    // Find the pixel tick and the counter values that the tick would load.
    always_comb begin
        tick_s   = enable && (div_cnt_r == DIV_LAST);
        h_wrap_s = (h_count == H_LAST);
        h_next_s = h_count;
        v_next_s = v_count;
        if (h_wrap_s) begin
            h_next_s = '0;
            if (v_count == V_LAST) begin
                v_next_s = '0;
            end else begin
                v_next_s = v_count + CNT_W'(1);
            end
        end else begin
            h_next_s = h_count + CNT_W'(1);
        end
    end

    // Registers for the divider, the counters, and all outputs decoded from the new counts.
    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            div_cnt_r   <= '0;
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            h_sync      <= ~H_SYNC_POL;
            v_sync      <= ~V_SYNC_POL;
            h_disp      <= 1'b0;
            v_disp      <= 1'b0;
            bright      <= 1'b0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            div_cnt_r   <= tick_s ? '0 : div_cnt_r + DIV_W'(1);
            pix_en      <= tick_s;
            line_start  <= tick_s && (h_next_s == '0);
            frame_start <= tick_s && (h_next_s == '0) && (v_next_s == '0);
            if (tick_s) begin
                h_count <= h_next_s;
                v_count <= v_next_s;
                h_sync  <= in_range(h_next_s, H_SYNC_LO, H_SYNC_HI) ? H_SYNC_POL : ~H_SYNC_POL;
                v_sync  <= in_range(v_next_s, V_SYNC_LO, V_SYNC_HI) ? V_SYNC_POL : ~V_SYNC_POL;
                h_disp  <= in_range(h_next_s, 0, H_DISP);
                v_disp  <= in_range(v_next_s, 0, V_DISP);
                bright  <= in_range(h_next_s, 0, H_DISP) && in_range(v_next_s, 0, V_DISP);
            end
        end else begin
            // Frozen: levels and the divider phase hold, and strobes drop.
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
